// File: rtl/row_deskew_collector_pkg.sv
// Shared lane geometry and row type for the deskew collector.
package row_deskew_collector_pkg;

  localparam int unsigned COL_NUM = 32;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ROW_W   = COL_NUM * DATA_W;

  typedef logic [COL_NUM-1:0][DATA_W-1:0] fp16_row_t;

  // Bit offset of a lane within a flattened row.
  function automatic int unsigned lane_lsb(input int unsigned lane);
    return lane * DATA_W;
  endfunction

endpackage

// File: rtl/row_deskew_collector_sync_fifo.sv
// Registered synchronous FIFO, no fall-through; head entry shown on rdata.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic                        do_push;
  logic                        do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/row_deskew_collector.sv
// Realigns diagonally skewed lanes into full rows and streams them out of a
// small FIFO with tile-end marking and a sticky overflow flag.
module row_deskew_collector
  import row_deskew_collector_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ROW_CNT_W = 8,
  localparam int unsigned LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROW_W-1:0]     diag_data_in,
  input  logic                 diag_valid_in,
  input  logic [ROW_CNT_W-1:0] cfg_tile_rows,
  output logic [ROW_W-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [LVL_W-1:0]     fifo_level,
  output logic                 overflow
);

  logic [COL_NUM-2:0]   valid_sr;
  logic                 aligned_valid;
  fp16_row_t            aligned_row;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic [ROW_CNT_W-1:0] row_cnt;

  // Lane-0 valid travels alongside the slowest delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_sr <= '0;
    end else begin
      valid_sr <= {valid_sr[COL_NUM-3:0], diag_valid_in};
    end
  end

  assign aligned_valid = valid_sr[COL_NUM-2];

  for (genvar i = 0; i < COL_NUM; i++) begin : g_lane
    localparam int unsigned STAGES = COL_NUM - 1 - i;
    localparam int unsigned LSB    = lane_lsb(i);
    if (STAGES == 0) begin : g_live
      assign aligned_row[i] = diag_data_in[LSB +: DATA_W];
    end else begin : g_dly
      localparam int unsigned DLY_W = STAGES * DATA_W;
      logic [STAGES-1:0][DATA_W-1:0] dly;
      always_ff @(posedge clk) begin
        if (rst) begin
          dly <= '0;
        end else begin
          dly <= DLY_W'({dly, diag_data_in[LSB +: DATA_W]});
        end
      end
      assign aligned_row[i] = dly[STAGES-1];
    end
  end

  assign pop  = out_valid && out_ready;
  assign push = aligned_valid && (!fifo_full || pop);

  sync_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (aligned_row),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign out_last  = out_valid && (cfg_tile_rows != '0) &&
                     (row_cnt == cfg_tile_rows - ROW_CNT_W'(1));

  // Tile row counter advances on accepted beats only; overflow is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (aligned_valid && !push) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        row_cnt <= out_last ? '0 : row_cnt + ROW_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_row_deskew_collector.sv
// Bench for row_deskew_collector: scheduled skewed rows checked every cycle
// against a queue-based reference, plus table-driven and hand-written scenarios.
module tb_row_deskew_collector;
  import row_deskew_collector_pkg::*;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned ROW_CNT_W = 8;
  localparam int unsigned LVL_W     = $clog2(DEPTH) + 1;
  localparam int          LAT       = int'(COL_NUM) - 1;

  typedef logic [ROW_W-1:0] row_t;

  typedef struct {
    int cfg;
    int nrows;
    int gap_max;
    int ready_pct;
    bit pat;
    int exp_beats;
    int exp_lasts;
    int exp_ovf;
  } vec_t;

  logic                 clk;
  logic                 rst;
  logic [ROW_W-1:0]     diag_data_in;
  logic                 diag_valid_in;
  logic [ROW_CNT_W-1:0] cfg_tile_rows;
  logic [ROW_W-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic [LVL_W-1:0]     fifo_level;
  logic                 overflow;

  row_deskew_collector #(.DEPTH(DEPTH), .ROW_CNT_W(ROW_CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .diag_data_in  (diag_data_in),
    .diag_valid_in (diag_valid_in),
    .cfg_tile_rows (cfg_tile_rows),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .fifo_level    (fifo_level),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rows keyed by the cycle their lane 0 is presented.
  row_t sched [int];
  int   last_start  = -1000;
  int   kill_before = -1000;
  int   cyc         = 0;
  row_t mq [$];
  int   mcnt        = 0;
  bit   movf        = 1'b0;
  bit   mrst_now    = 1'b0;
  bit   garbage_ffff = 1'b0;
  int   ready_pct   = 100;
  int   beats       = 0;
  int   lasts       = 0;
  int   first_valid = -1;
  row_t first_data;
  int   checks      = 0;
  int   errors      = 0;

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_row(input string nm, input row_t act, input row_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit m_last();
    return (mq.size() != 0) && (cfg_tile_rows != '0) &&
           (mcnt == int'(cfg_tile_rows) - 1);
  endfunction

  function automatic row_t make_row(input bit pat, input int r);
    row_t x;
    for (int i = 0; i < int'(COL_NUM); i++) begin
      x[i*DATA_W +: DATA_W] = pat ? {8'(r), 8'(i)} : DATA_W'($urandom);
    end
    return x;
  endfunction

  task automatic schedule(input int s, input row_t r);
    sched[s] = r;
    if (s > last_start) last_start = s;
  endtask

  // Present lane i of the row whose lane 0 was at cyc-i; otherwise junk.
  task automatic drive();
    diag_valid_in = sched.exists(cyc);
    for (int i = 0; i < int'(COL_NUM); i++) begin
      logic [DATA_W-1:0] v;
      row_t r;
      if (sched.exists(cyc - i)) begin
        r = sched[cyc - i];
        v = r[i*DATA_W +: DATA_W];
      end else begin
        v = garbage_ffff ? 16'hFFFF : DATA_W'($urandom);
      end
      diag_data_in[i*DATA_W +: DATA_W] = v;
    end
  endtask

  // Reference: a row is whole LAT cycles after its lane 0, joins the queue if
  // there is room once this cycle's pop is accounted for, else it is lost.
  task automatic model_edge();
    bit popped;
    int s;
    mrst_now = rst;
    if (rst) begin
      mq.delete();
      mcnt        = 0;
      movf        = 1'b0;
      kill_before = cyc;
    end else begin
      popped = (mq.size() != 0) && out_ready;
      s      = cyc - LAT;
      if (popped) begin
        mcnt = m_last() ? 0 : (mcnt + 1) % 256;
        void'(mq.pop_front());
      end
      if (sched.exists(s) && s > kill_before) begin
        if (mq.size() < int'(DEPTH)) mq.push_back(sched[s]);
        else movf = 1'b1;
      end
    end
  endtask

  task automatic compare();
    chk_int("out_valid", int'(out_valid), int'(mq.size() != 0));
    chk_int("fifo_level", int'(fifo_level), mq.size());
    chk_int("overflow", int'(overflow), int'(movf));
    chk_int("out_last", int'(out_last), int'(m_last()));
    if (mq.size() != 0) chk_row("out_data", out_data, mq[0]);
    else if (mrst_now) chk_row("out_data_rst", out_data, '0);
  endtask

  task automatic tick();
    bit pv;
    bit pl;
    drive();
    pv = out_valid;
    pl = out_last;
    @(posedge clk);
    if (pv && out_ready && !rst) begin
      beats++;
      if (pl) lasts++;
    end
    model_edge();
    #1;
    compare();
    if (out_valid && first_valid < 0) begin
      first_valid = cyc;
      first_data  = out_data;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_idle(input int budget);
    for (int n = 0; ; n++) begin
      if (cyc > last_start + int'(COL_NUM) && mq.size() == 0) break;
      if (n >= budget) begin
        checks++;
        errors++;
        $display("FAIL run_idle: drain not reached after %0d cycles, level %0d", n, mq.size());
        break;
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      tick();
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int s;
    int s0;
    do_reset();
    cfg_tile_rows = ROW_CNT_W'(v.cfg);
    garbage_ffff  = 1'b0;
    ready_pct     = v.ready_pct;
    beats         = 0;
    lasts         = 0;
    first_valid   = -1;
    s  = cyc + 1;
    s0 = s;
    for (int r = 0; r < v.nrows; r++) begin
      schedule(s, make_row(v.pat, r));
      s += 1 + int'($urandom_range(0, v.gap_max));
    end
    run_idle(20000);
    if (v.exp_beats >= 0) begin
      chk_int($sformatf("vec%0d_beats", idx), beats, v.exp_beats);
      chk_int($sformatf("vec%0d_lasts", idx), lasts, v.exp_lasts);
      chk_int($sformatf("vec%0d_ovf", idx), int'(overflow), v.exp_ovf);
    end
    if (v.ready_pct == 100) chk_int($sformatf("vec%0d_latency", idx), first_valid - s0, LAT);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [5];
    row_t exp_row;
    int   s;
    int   s2;

    rst           = 1'b1;
    out_ready     = 1'b1;
    cfg_tile_rows = '0;
    diag_valid_in = 1'b0;
    diag_data_in  = '0;

    vecs[0] = '{cfg: 8, nrows: 8,   gap_max: 0, ready_pct: 100, pat: 1'b1, exp_beats: 8,   exp_lasts: 1,  exp_ovf: 0};
    vecs[1] = '{cfg: 0, nrows: 300, gap_max: 0, ready_pct: 100, pat: 1'b0, exp_beats: 300, exp_lasts: 0,  exp_ovf: 0};
    vecs[2] = '{cfg: 3, nrows: 12,  gap_max: 2, ready_pct: 100, pat: 1'b0, exp_beats: 12,  exp_lasts: 4,  exp_ovf: 0};
    vecs[3] = '{cfg: 5, nrows: 40,  gap_max: 3, ready_pct: 60,  pat: 1'b0, exp_beats: -1,  exp_lasts: -1, exp_ovf: -1};
    vecs[4] = '{cfg: 7, nrows: 60,  gap_max: 1, ready_pct: 35,  pat: 1'b0, exp_beats: -1,  exp_lasts: -1, exp_ovf: -1};

    // Reset state.
    do_reset();
    chk_int("reset_valid", int'(out_valid), 0);
    chk_int("reset_level", int'(fifo_level), 0);
    chk_row("reset_data", out_data, '0);

    // Single row with 0xFFFF junk outside its window.
    do_reset();
    cfg_tile_rows = '0;
    garbage_ffff  = 1'b1;
    ready_pct     = 100;
    for (int i = 0; i < int'(COL_NUM); i++) exp_row[i*DATA_W +: DATA_W] = DATA_W'(16'h3C00 + i);
    s = cyc + 1;
    schedule(s, exp_row);
    beats = 0;
    first_valid = -1;
    run_idle(200);
    chk_int("single_latency", first_valid - s, LAT);
    chk_int("single_beats", beats, 1);
    chk_row("single_data", first_data, exp_row);
    chk_int("single_level_end", int'(fifo_level), 0);
    garbage_ffff = 1'b0;

    foreach (vecs[k]) run_vec(vecs[k], k);

    // Backpressure: five rows into a 4-deep FIFO, the fifth is dropped.
    do_reset();
    cfg_tile_rows = ROW_CNT_W'(4);
    s = cyc + 1;
    for (int r = 0; r < 5; r++) schedule(s + r, make_row(1'b0, r));
    while (cyc <= s + 4 + LAT) begin
      out_ready = 1'b0;
      tick();
    end
    chk_int("bp_level", int'(fifo_level), int'(DEPTH));
    chk_int("bp_overflow", int'(overflow), 1);
    repeat (3) tick();
    ready_pct = 100;
    beats = 0;
    lasts = 0;
    run_idle(200);
    chk_int("bp_beats", beats, 4);
    chk_int("bp_lasts", lasts, 1);
    chk_int("bp_overflow_sticky", int'(overflow), 1);

    // Reset ten cycles into a wave, with sticky overflow and stale data present.
    s = cyc + 1;
    schedule(s, make_row(1'b0, 0));
    while (cyc < s + 10) begin
      out_ready = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_int("rst_valid", int'(out_valid), 0);
    chk_int("rst_last", int'(out_last), 0);
    chk_int("rst_level", int'(fifo_level), 0);
    chk_int("rst_overflow", int'(overflow), 0);
    chk_row("rst_data", out_data, '0);
    s2 = s + 20;
    schedule(s2, make_row(1'b0, 1));
    beats = 0;
    first_valid = -1;
    run_idle(200);
    chk_int("rst_fresh_latency", first_valid - s2, LAT);
    chk_int("rst_fresh_beats", beats, 1);
    chk_row("rst_fresh_data", first_data, sched[s2]);

    // Full FIFO with a pop in the cycle the fifth row aligns.
    do_reset();
    cfg_tile_rows = '0;
    s = cyc + 1;
    for (int r = 0; r < 4; r++) schedule(s + r, make_row(1'b0, r));
    schedule(s + 6, make_row(1'b0, 4));
    while (cyc < s + 6 + LAT) begin
      out_ready = 1'b0;
      tick();
    end
    chk_int("full_pre_level", int'(fifo_level), int'(DEPTH));
    out_ready = 1'b1;
    beats = 0;
    tick();
    chk_int("full_pp_level", int'(fifo_level), int'(DEPTH));
    chk_int("full_pp_overflow", int'(overflow), 0);
    ready_pct = 100;
    run_idle(200);
    chk_int("full_pp_beats", beats, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
